zxw_cam_sync: RTL and testbench

Synchronous, parametrised content-addressable memory; the next generation of the team's 16x6 asynchronous CAM. It adds a clock, per-entry valid bits, entry invalidate, a two-stage registered search pipeline, a priority-encoded hit address, multi-hit detection and an occupancy counter. It serves as the lookup table in the match/tag datapath, with the host writing entries and search logic presenting arguments.

---
 rtl/zxw_cam_sync.sv | 234 +++++++++++++++++++++++
 tb/tb_zxw_cam_sync.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/zxw_cam_sync.sv
// zxw_cam_sync: synchronous content-addressable memory with per-entry valid
// bits, entry invalidate, a two-stage registered search pipeline, lowest-index
// hit address, multi-hit detection and an occupancy counter.
// Optional ternary compare: define TERNARY_MASK_EN to add a per-entry mask
// (mkin/mkout ports); a stored mask bit of 1 makes that bit a don't-care.
// The write, read and clear operations all use the single addrs port, so a
// write and a clear in the same cycle always target the same entry.
module zxw_cam_sync #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_n,
  input  logic             rd_n,
  input  logic             clr_n,
  input  logic [AW-1:0]    addrs,
  input  logic [WIDTH-1:0] din,
`ifdef TERNARY_MASK_EN
  input  logic [WIDTH-1:0] mkin,
  output logic [WIDTH-1:0] mkout,
`endif
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic             dout_hit,
  input  logic             srch,
  input  logic [WIDTH-1:0] argin,
  output logic [DEPTH-1:0] mbits,
  output logic             hit,
  output logic [AW-1:0]    hit_addr,
  output logic             multi_hit,
  output logic             srch_vld,
  output logic [AW:0]      cnt
);

  localparam logic [AW:0]      CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [DEPTH-1:0] VEC_ONE  = {{(DEPTH-1){1'b0}}, 1'b1};
  localparam logic [DEPTH-1:0] VEC_ZERO = {DEPTH{1'b0}};
  localparam logic [WIDTH-1:0] DAT_ZERO = {WIDTH{1'b0}};

  // Lowest set index of a match vector; 0 when the vector is empty.
  function automatic logic [AW-1:0] prio_enc(input logic [DEPTH-1:0] v);
    logic [AW-1:0] idx;
    idx = {AW{1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = i[AW-1:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // True when at least two bits are set: clearing the lowest set bit
  // leaves something behind.
  function automatic logic two_or_more(input logic [DEPTH-1:0] v);
    return ((v & (v - VEC_ONE)) != VEC_ZERO);
  endfunction

  // Storage and valid bits
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [AW:0]                 cnt_q, cnt_d;
`ifdef TERNARY_MASK_EN
  logic [DEPTH-1:0][WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0]            mkout_q, mkout_d;
`endif

  // Read port
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_vld_q, dout_vld_d;
  logic             dout_hit_q, dout_hit_d;

  // Search pipeline
  logic [WIDTH-1:0] arg_q, arg_d;
  logic             s1_vld_q, s1_vld_d;
  logic [DEPTH-1:0] match_s;
  logic [DEPTH-1:0] mbits_q, mbits_d;
  logic             hit_q, hit_d;
  logic [AW-1:0]    hit_addr_q, hit_addr_d;
  logic             multi_hit_q, multi_hit_d;
  logic             srch_vld_q, srch_vld_d;

  // Array update: data is written whenever we_n is low; clear overrides the
  // valid bit on the same entry and the count moves only on a real change.
  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
`ifdef TERNARY_MASK_EN
    mask_d  = mask_q;
`endif
    if (!we_n) begin
      mem_d[addrs] = din;
`ifdef TERNARY_MASK_EN
      mask_d[addrs] = mkin;
`endif
    end else begin
      mem_d = mem_q;
    end
    if (!clr_n) begin
      valid_d[addrs] = 1'b0;
      if (valid_q[addrs]) begin
        cnt_d = cnt_q - CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end else if (!we_n) begin
      valid_d[addrs] = 1'b1;
      if (!valid_q[addrs]) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Read port: samples the array as it stands before this edge, so a
  // same-edge write is not visible; dout holds between reads.
  always_comb begin
    dout_d     = dout_q;
    dout_hit_d = dout_hit_q;
    dout_vld_d = 1'b0;
`ifdef TERNARY_MASK_EN
    mkout_d    = mkout_q;
`endif
    if (!rd_n) begin
      dout_d     = mem_q[addrs];
      dout_hit_d = valid_q[addrs];
      dout_vld_d = 1'b1;
`ifdef TERNARY_MASK_EN
      mkout_d    = mask_q[addrs];
`endif
    end else begin
      dout_vld_d = 1'b0;
    end
  end

  // Compare the registered argument against every valid entry.
  always_comb begin
    match_s = VEC_ZERO;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef TERNARY_MASK_EN
      match_s[i] = valid_q[i] && (((mem_q[i] ^ arg_q) & ~mask_q[i]) == DAT_ZERO);
`else
      match_s[i] = valid_q[i] && ((mem_q[i] ^ arg_q) == DAT_ZERO);
`endif
    end
  end

  // Search pipeline: stage 1 captures the argument, stage 2 registers the
  // compare results; results hold until the next completed search.
  always_comb begin
    arg_d       = arg_q;
    s1_vld_d    = srch;
    mbits_d     = mbits_q;
    hit_d       = hit_q;
    hit_addr_d  = hit_addr_q;
    multi_hit_d = multi_hit_q;
    srch_vld_d  = s1_vld_q;
    if (srch) begin
      arg_d = argin;
    end else begin
      arg_d = arg_q;
    end
    if (s1_vld_q) begin
      mbits_d     = match_s;
      hit_d       = (match_s != VEC_ZERO);
      hit_addr_d  = prio_enc(match_s);
      multi_hit_d = two_or_more(match_s);
    end else begin
      mbits_d = mbits_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q       <= '0;
      valid_q     <= VEC_ZERO;
      cnt_q       <= {(AW+1){1'b0}};
`ifdef TERNARY_MASK_EN
      mask_q      <= '0;
      mkout_q     <= DAT_ZERO;
`endif
      dout_q      <= DAT_ZERO;
      dout_vld_q  <= 1'b0;
      dout_hit_q  <= 1'b0;
      arg_q       <= DAT_ZERO;
      s1_vld_q    <= 1'b0;
      mbits_q     <= VEC_ZERO;
      hit_q       <= 1'b0;
      hit_addr_q  <= {AW{1'b0}};
      multi_hit_q <= 1'b0;
      srch_vld_q  <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
`ifdef TERNARY_MASK_EN
      mask_q      <= mask_d;
      mkout_q     <= mkout_d;
`endif
      dout_q      <= dout_d;
      dout_vld_q  <= dout_vld_d;
      dout_hit_q  <= dout_hit_d;
      arg_q       <= arg_d;
      s1_vld_q    <= s1_vld_d;
      mbits_q     <= mbits_d;
      hit_q       <= hit_d;
      hit_addr_q  <= hit_addr_d;
      multi_hit_q <= multi_hit_d;
      srch_vld_q  <= srch_vld_d;
    end
  end

  assign dout      = dout_q;
  assign dout_vld  = dout_vld_q;
  assign dout_hit  = dout_hit_q;
  assign mbits     = mbits_q;
  assign hit       = hit_q;
  assign hit_addr  = hit_addr_q;
  assign multi_hit = multi_hit_q;
  assign srch_vld  = srch_vld_q;
  assign cnt       = cnt_q;
`ifdef TERNARY_MASK_EN
  assign mkout     = mkout_q;
`endif

endmodule

// File: tb/tb_zxw_cam_sync.sv
// Directed bench for zxw_cam_sync (WIDTH=6, DEPTH=16): hand-computed
// expectations checked with immediate assertions after each clock edge.
module tb_zxw_cam_sync;

  logic        clk;
  logic        rst;
  logic        we_n, rd_n, clr_n, srch;
  logic [3:0]  addrs;
  logic [5:0]  din, argin;
  logic [5:0]  dout;
  logic        dout_vld, dout_hit;
  logic [15:0] mbits;
  logic        hit, multi_hit, srch_vld;
  logic [3:0]  hit_addr;
  logic [4:0]  cnt;
`ifdef TERNARY_MASK_EN
  logic [5:0]  mkin, mkout;
`endif

  int vectors;
  int miscompares;

  zxw_cam_sync #(.WIDTH(6), .DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .we_n(we_n), .rd_n(rd_n), .clr_n(clr_n),
    .addrs(addrs), .din(din),
`ifdef TERNARY_MASK_EN
    .mkin(mkin), .mkout(mkout),
`endif
    .dout(dout), .dout_vld(dout_vld), .dout_hit(dout_hit),
    .srch(srch), .argin(argin), .mbits(mbits), .hit(hit),
    .hit_addr(hit_addr), .multi_hit(multi_hit), .srch_vld(srch_vld),
    .cnt(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; we_n = 1'b1; rd_n = 1'b1; clr_n = 1'b1; srch = 1'b0;
    addrs = 4'd0; din = 6'd0; argin = 6'd0;
`ifdef TERNARY_MASK_EN
    mkin = 6'd0;
`endif
    step(); step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_dout", dout, 6'd0);
    chk("rst_dout_vld", dout_vld, 1'b0);
    chk("rst_dout_hit", dout_hit, 1'b0);
    chk("rst_mbits", mbits, 16'h0000);
    chk("rst_hit", hit, 1'b0);
    chk("rst_hit_addr", hit_addr, 4'd0);
    chk("rst_multi", multi_hit, 1'b0);
    chk("rst_srch_vld", srch_vld, 1'b0);
    chk("rst_cnt", cnt, 5'd0);

    // Search 0 against empty array: invalid entries never match
    srch = 1'b1; argin = 6'b000000;
    step();
    srch = 1'b0;
    chk("s0_lat1_vld", srch_vld, 1'b0);
    step();
    chk("s0_vld", srch_vld, 1'b1);
    chk("s0_mbits", mbits, 16'h0000);
    chk("s0_hit", hit, 1'b0);
    chk("s0_cnt", cnt, 5'd0);

    // Fill every entry with 010101
    for (int i = 0; i < 16; i++) begin
      we_n = 1'b0; addrs = i[3:0]; din = 6'b010101;
      step();
    end
    we_n = 1'b1;
    chk("fill_cnt", cnt, 5'd16);

    srch = 1'b1; argin = 6'b010101;
    step();
    srch = 1'b0;
    step();
    chk("all_vld", srch_vld, 1'b1);
    chk("all_mbits", mbits, 16'hFFFF);
    chk("all_hit", hit, 1'b1);
    chk("all_hit_addr", hit_addr, 4'd0);
    chk("all_multi", multi_hit, 1'b1);
    step();
    chk("hold_vld", srch_vld, 1'b0);
    chk("hold_mbits", mbits, 16'hFFFF);

    // Overwrite entry 5 (already valid: count stays saturated)
    we_n = 1'b0; addrs = 4'd5; din = 6'b111111;
    step();
    we_n = 1'b1;
    chk("ow_cnt", cnt, 5'd16);

    // Back-to-back searches: 111111 then 010101
    srch = 1'b1; argin = 6'b111111;
    step();
    argin = 6'b010101;
    step();
    srch = 1'b0;
    chk("b2b1_vld", srch_vld, 1'b1);
    chk("b2b1_mbits", mbits, 16'h0020);
    chk("b2b1_hit_addr", hit_addr, 4'd5);
    chk("b2b1_multi", multi_hit, 1'b0);
    chk("b2b1_hit", hit, 1'b1);
    step();
    chk("b2b2_vld", srch_vld, 1'b1);
    chk("b2b2_mbits", mbits, 16'hFFDF);
    chk("b2b2_hit_addr", hit_addr, 4'd0);

    // Write at the stage-1 edge is visible, clear at the stage-2 edge is not
    srch = 1'b1; argin = 6'b010101; we_n = 1'b0; addrs = 4'd5; din = 6'b010101;
    step();
    srch = 1'b0; we_n = 1'b1; clr_n = 1'b0; addrs = 4'd0;
    step();
    clr_n = 1'b1;
    chk("clr_race_mbits", mbits, 16'hFFFF);
    chk("clr_cnt", cnt, 5'd15);
    srch = 1'b1;
    step();
    srch = 1'b0;
    step();
    chk("post_clr_mbits", mbits, 16'hFFFE);
    chk("post_clr_hit_addr", hit_addr, 4'd1);
    chk("post_clr_multi", multi_hit, 1'b1);
    chk("post_clr_cnt", cnt, 5'd15);

    // Read with a same-edge write returns old data, then re-read
    rd_n = 1'b0; we_n = 1'b0; addrs = 4'd3; din = 6'b101010;
    step();
    we_n = 1'b1;
    chk("rdw_dout", dout, 6'b010101);
    chk("rdw_hit", dout_hit, 1'b1);
    chk("rdw_vld", dout_vld, 1'b1);
    step();
    chk("reread_dout", dout, 6'b101010);
    chk("reread_hit", dout_hit, 1'b1);
    addrs = 4'd0;
    step();
    rd_n = 1'b1;
    chk("rd_cleared_hit", dout_hit, 1'b0);
    chk("rd_cleared_dout", dout, 6'b010101);
    step();
    chk("rd_idle_vld", dout_vld, 1'b0);
    chk("rd_hold_dout", dout, 6'b010101);
    chk("cnt_after_rd", cnt, 5'd15);

    // Reset one cycle after srch discards the in-flight search
    srch = 1'b1; argin = 6'b010101;
    step();
    srch = 1'b0;
    #2 rst = 1'b1;
    step();
    chk("rst_mid_vld", srch_vld, 1'b0);
    rst = 1'b0;
    step();
    chk("rst_mid_vld2", srch_vld, 1'b0);
    chk("rst_mid_mbits", mbits, 16'h0000);
    chk("rst_mid_hit", hit, 1'b0);
    chk("rst_mid_cnt", cnt, 5'd0);
    chk("rst_mid_dout", dout, 6'd0);

    // Storage cleared to 0 but invalid: argument 0 must not match
    srch = 1'b1; argin = 6'b000000;
    step();
    srch = 1'b0;
    step();
    chk("zero_arg_vld", srch_vld, 1'b1);
    chk("zero_arg_mbits", mbits, 16'h0000);

`ifdef TERNARY_MASK_EN
    we_n = 1'b0; addrs = 4'd2; din = 6'b110000; mkin = 6'b001111;
    step();
    we_n = 1'b1; mkin = 6'd0;
    srch = 1'b1; argin = 6'b110101;
    step();
    srch = 1'b0;
    step();
    chk("tern_mbits", mbits, 16'h0004);
    chk("tern_hit_addr", hit_addr, 4'd2);
    rd_n = 1'b0; addrs = 4'd2;
    step();
    rd_n = 1'b1;
    chk("tern_mkout", mkout, 6'b001111);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
